// File: rtl/pia_term.sv
// Apple-1 style 6820 PIA emulation: a keyboard FIFO and a display byte
// handshake exposed to the 6502 bus as KBD, KBDCR, DSP and DSPCR.
module pia_term #(
  parameter int FIFO_DEPTH = 4,
  parameter int UPCASE     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] address,
  input  logic       w_en,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       kbd_valid,
  input  logic [7:0] kbd_data,
  output logic       kbd_ready,
  output logic       dsp_valid,
  output logic [6:0] dsp_data,
  input  logic       dsp_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] ADDR_KBD   = 2'd0;
  localparam logic [1:0] ADDR_KBDCR = 2'd1;
  localparam logic [1:0] ADDR_DSP   = 2'd2;
  localparam logic [1:0] ADDR_DSPCR = 2'd3;

  logic [6:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [6:0]    kbdcr_reg;
  logic [6:0]    dspcr_reg;
  logic          dsp_valid_reg;
  logic [6:0]    dsp_data_reg;
  logic [7:0]    dout_reg;

  logic       rd_access;
  logic       wr_access;
  logic       non_empty;
  logic       full;
  logic       push;
  logic       pop;
  logic [6:0] store_byte;
  logic [7:0] read_data;
  logic       unused_bits;

  // Bit 7 of keyboard bytes and of CPU data is meaningless to this device.
  assign unused_bits = ^{din[7], kbd_data[7]};

  assign rd_access = enable & ~w_en;
  assign wr_access = enable & w_en;
  assign non_empty = (count_reg != '0);
  assign full      = (count_reg == CW'(FIFO_DEPTH));
  assign push      = kbd_valid & ~full;
  assign pop       = rd_access & (address == ADDR_KBD) & non_empty;

  assign kbd_ready = ~full;
  assign dsp_valid = dsp_valid_reg;
  assign dsp_data  = dsp_data_reg;
  assign dout      = dout_reg;

  always_comb begin
    store_byte = kbd_data[6:0];
    if (UPCASE != 0 && kbd_data[6:0] >= 7'h61 && kbd_data[6:0] <= 7'h7a) begin
      store_byte = {kbd_data[6], 1'b0, kbd_data[4:0]};
    end
  end

  always_comb begin
    read_data = 8'h00;
    case (address)
      ADDR_KBD:   read_data = non_empty ? {1'b1, fifo_mem[rd_ptr_reg]} : 8'h00;
      ADDR_KBDCR: read_data = {non_empty, kbdcr_reg};
      ADDR_DSP:   read_data = {dsp_valid_reg, dsp_data_reg};
      ADDR_DSPCR: read_data = {1'b0, dspcr_reg};
      default:    read_data = 8'h00;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= store_byte;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kbdcr_reg <= 7'h00;
      dspcr_reg <= 7'h00;
    end else if (wr_access) begin
      if (address == ADDR_KBDCR) begin
        kbdcr_reg <= din[6:0];
      end
      if (address == ADDR_DSPCR) begin
        dspcr_reg <= din[6:0];
      end
    end
  end

  // A DSP write is only taken when not busy as sampled on this edge, so a
  // write coinciding with the sink handshake is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dsp_valid_reg <= 1'b0;
      dsp_data_reg  <= 7'h00;
    end else if (dsp_valid_reg && dsp_ready) begin
      dsp_valid_reg <= 1'b0;
    end else if (wr_access && address == ADDR_DSP && !dsp_valid_reg) begin
      dsp_valid_reg <= 1'b1;
      dsp_data_reg  <= din[6:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_reg <= 8'h00;
    end else if (rd_access) begin
      dout_reg <= read_data;
    end
  end

endmodule
